// File: rtl/ap_txn_profiler.sv
// Transaction profiler for NUM_CH ap_ctrl_chain handshakes: per-channel counts,
// latency statistics and stall cycles, read back through a request/response port.
module ap_txn_profiler #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              clear,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              err_any
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;

    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   fifo_q      [NUM_CH][DEPTH];
    logic [NUM_CH-1:0] fifo_we_s;
    logic [PW-1:0]     wr_ptr_q    [NUM_CH];
    logic [PW-1:0]     wr_ptr_d    [NUM_CH];
    logic [PW-1:0]     rd_ptr_q    [NUM_CH];
    logic [PW-1:0]     rd_ptr_d    [NUM_CH];
    logic [CNT_W-1:0]  started_q   [NUM_CH];
    logic [CNT_W-1:0]  started_d   [NUM_CH];
    logic [CNT_W-1:0]  completed_q [NUM_CH];
    logic [CNT_W-1:0]  completed_d [NUM_CH];
    logic [CNT_W-1:0]  stall_cyc_q [NUM_CH];
    logic [CNT_W-1:0]  stall_cyc_d [NUM_CH];
    logic [CNT_W-1:0]  last_lat_q  [NUM_CH];
    logic [CNT_W-1:0]  last_lat_d  [NUM_CH];
    logic [CNT_W-1:0]  max_lat_q   [NUM_CH];
    logic [CNT_W-1:0]  max_lat_d   [NUM_CH];
    logic [CNT_W-1:0]  min_lat_q   [NUM_CH];
    logic [CNT_W-1:0]  min_lat_d   [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d, udf_q, udf_d;
    logic              frozen_q, frozen_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              err_any_q, err_any_d;
    logic [NUM_CH-1:0] push_s, pop_s, stall_s;

    assign push_s   = ap_start & ap_ready;
    assign pop_s    = ap_done & ap_continue;
    assign stall_s  = ap_done & ~ap_continue;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err_any  = err_any_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Flags occupy the top three bits; occupancy fills from bit 0 underneath them.
    function automatic logic [CNT_W-1:0] pack_status(input logic o, input logic u,
                                                     input logic f, input logic [PW-1:0] occ);
        logic [CNT_W-1:0] s;
        s            = CNT_W'(occ);
        s[CNT_W-1]   = o;
        s[CNT_W-2]   = u;
        s[CNT_W-3]   = f;
        return s;
    endfunction

    // Free-running timestamp; unaffected by freeze and clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Per-channel event processing: FIFO pointers, counters, latency stats, error flags.
    always_comb begin
        logic             empty_v;
        logic             full_v;
        logic [TS_W-1:0]  diff_v;
        logic [CNT_W-1:0] lat_v;
        empty_v   = 1'b0;
        full_v    = 1'b0;
        diff_v    = '0;
        lat_v     = '0;
        fifo_we_s = '0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        frozen_d  = clear ? 1'b0 : (frozen_q | finish);
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c]    = wr_ptr_q[c];
            rd_ptr_d[c]    = rd_ptr_q[c];
            started_d[c]   = started_q[c];
            completed_d[c] = completed_q[c];
            stall_cyc_d[c] = stall_cyc_q[c];
            last_lat_d[c]  = last_lat_q[c];
            max_lat_d[c]   = max_lat_q[c];
            min_lat_d[c]   = min_lat_q[c];
            empty_v = (wr_ptr_q[c] == rd_ptr_q[c]);
            full_v  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                      (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
            diff_v  = ts_q - fifo_q[c][rd_ptr_q[c][AW-1:0]];
            lat_v   = empty_v ? '0 : CNT_W'(diff_v);
            if (clear) begin
                wr_ptr_d[c]    = '0;
                rd_ptr_d[c]    = '0;
                started_d[c]   = '0;
                completed_d[c] = '0;
                stall_cyc_d[c] = '0;
                last_lat_d[c]  = '0;
                max_lat_d[c]   = '0;
                min_lat_d[c]   = '1;
                ovf_d[c]       = 1'b0;
                udf_d[c]       = 1'b0;
            end else if (!frozen_q) begin
                if (push_s[c]) begin
                    started_d[c] = sat_inc(started_q[c]);
                    // A push+pop on an empty FIFO bypasses storage with zero latency.
                    if (pop_s[c] && empty_v) begin
                        fifo_we_s[c] = 1'b0;
                    end else if (full_v && !pop_s[c]) begin
                        ovf_d[c] = 1'b1;
                    end else begin
                        fifo_we_s[c] = 1'b1;
                        wr_ptr_d[c]  = wr_ptr_q[c] + PW'(1);
                    end
                end else begin
                    started_d[c] = started_q[c];
                end
                if (pop_s[c]) begin
                    completed_d[c] = sat_inc(completed_q[c]);
                    if (empty_v && !push_s[c]) begin
                        udf_d[c] = 1'b1;
                    end else begin
                        rd_ptr_d[c]   = empty_v ? rd_ptr_q[c] : rd_ptr_q[c] + PW'(1);
                        last_lat_d[c] = lat_v;
                        max_lat_d[c]  = (lat_v > max_lat_q[c]) ? lat_v : max_lat_q[c];
                        min_lat_d[c]  = (lat_v < min_lat_q[c]) ? lat_v : min_lat_q[c];
                    end
                end else begin
                    completed_d[c] = completed_q[c];
                end
                if (stall_s[c]) begin
                    stall_cyc_d[c] = sat_inc(stall_cyc_q[c]);
                end else begin
                    stall_cyc_d[c] = stall_cyc_q[c];
                end
            end else begin
                started_d[c] = started_q[c];
            end
        end
    end

    // Readout mux; samples pre-edge statistics so same-edge updates are not visible.
    always_comb begin
        rd_valid_d = rd_en & ~clear;
        rd_data_d  = '0;
        err_any_d  = clear ? 1'b0 : |(ovf_q | udf_q);
        if (rd_en && !clear && (32'(rd_ch) < NUM_CH)) begin
            case (rd_sel)
                3'd0:    rd_data_d = started_q[rd_ch];
                3'd1:    rd_data_d = completed_q[rd_ch];
                3'd2:    rd_data_d = last_lat_q[rd_ch];
                3'd3:    rd_data_d = max_lat_q[rd_ch];
                3'd4:    rd_data_d = min_lat_q[rd_ch];
                3'd5:    rd_data_d = stall_cyc_q[rd_ch];
                3'd6:    rd_data_d = pack_status(ovf_q[rd_ch], udf_q[rd_ch], frozen_q,
                                                 wr_ptr_q[rd_ch] - rd_ptr_q[rd_ch]);
                3'd7:    rd_data_d = CNT_W'(ts_q);
                default: rd_data_d = '0;
            endcase
        end else begin
            rd_data_d = '0;
        end
    end

    // Statistic, pointer, flag and readout registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen_q   <= 1'b0;
            ovf_q      <= '0;
            udf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_any_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c]    <= '0;
                rd_ptr_q[c]    <= '0;
                started_q[c]   <= '0;
                completed_q[c] <= '0;
                stall_cyc_q[c] <= '0;
                last_lat_q[c]  <= '0;
                max_lat_q[c]   <= '0;
                min_lat_q[c]   <= '1;
            end
        end else begin
            frozen_q   <= frozen_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_any_q  <= err_any_d;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c]    <= wr_ptr_d[c];
                rd_ptr_q[c]    <= rd_ptr_d[c];
                started_q[c]   <= started_d[c];
                completed_q[c] <= completed_d[c];
                stall_cyc_q[c] <= stall_cyc_d[c];
                last_lat_q[c]  <= last_lat_d[c];
                max_lat_q[c]   <= max_lat_d[c];
                min_lat_q[c]   <= min_lat_d[c];
            end
        end
    end

    // Start-timestamp FIFO storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_q[c][i] <= '0;
                end
            end
        end else if (clear) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_q[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fifo_we_s[c]) begin
                    fifo_q[c][wr_ptr_q[c][AW-1:0]] <= ts_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed bench for ap_txn_profiler: a default instance and a narrow
// (TS_W=4, CNT_W=4, DEPTH=2, NUM_CH=3) instance for wrap and saturation.
module tb_ap_txn_profiler;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        fin0, clr0, rd_en0, rd_valid0, err_any0;
    logic [3:0]  st0, rdy0, dn0, ct0;
    logic [1:0]  rd_ch0;
    logic [2:0]  rd_sel0;
    logic [31:0] rd_data0;

    logic        fin1, clr1, rd_en1, rd_valid1, err_any1;
    logic [2:0]  st1, rdy1, dn1, ct1;
    logic [1:0]  rd_ch1;
    logic [2:0]  rd_sel1;
    logic [3:0]  rd_data1;

    ap_txn_profiler #(.NUM_CH(4), .DEPTH(4), .TS_W(16), .CNT_W(32)) u_d0 (
        .clock(clk), .reset(rst_n), .finish(fin0), .clear(clr0),
        .ap_start(st0), .ap_ready(rdy0), .ap_done(dn0), .ap_continue(ct0),
        .rd_en(rd_en0), .rd_ch(rd_ch0), .rd_sel(rd_sel0),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .err_any(err_any0));

    ap_txn_profiler #(.NUM_CH(3), .DEPTH(2), .TS_W(4), .CNT_W(4)) u_d1 (
        .clock(clk), .reset(rst_n), .finish(fin1), .clear(clr1),
        .ap_start(st1), .ap_ready(rdy1), .ap_done(dn1), .ap_continue(ct1),
        .rd_en(rd_en1), .rd_ch(rd_ch1), .rd_sel(rd_sel1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .err_any(err_any1));

    int vectors = 0;
    int miscompares = 0;
    int tb_ts = 0;
    logic [31:0] q0_exp[$];
    string       q0_tag[$];
    logic [3:0]  q1_exp[$];
    string       q1_tag[$];
    logic [31:0] e0;
    logic [3:0]  e1;
    string       t0, t1;

    // Reference timestamp: value the DUT's ts holds between edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 0;
        else        tb_ts <= tb_ts + 1;
    end

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        if (rd_valid0) begin
            vectors++;
            if (q0_exp.size() == 0) begin
                miscompares++;
                $error("FAIL d0_spurious_valid: observed rd_valid 1, expected 0");
            end else begin
                e0 = q0_exp.pop_front();
                t0 = q0_tag.pop_front();
                assert (rd_data0 === e0) else begin
                    miscompares++;
                    $error("FAIL %s: observed %0h expected %0h", t0, rd_data0, e0);
                end
            end
        end
    end

    // Scoreboard for the narrow instance.
    always @(negedge clk) begin
        if (rd_valid1) begin
            vectors++;
            if (q1_exp.size() == 0) begin
                miscompares++;
                $error("FAIL d1_spurious_valid: observed rd_valid 1, expected 0");
            end else begin
                e1 = q1_exp.pop_front();
                t1 = q1_tag.pop_front();
                assert (rd_data1 === e1) else begin
                    miscompares++;
                    $error("FAIL %s: observed %0h expected %0h", t1, rd_data1, e1);
                end
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto_ts(input int t);
        int n = 0;
        while (tb_ts != t && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(32'(tb_ts), 32'(t), "goto_ts_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rd0(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] exp,
                       input string tag);
        rd_en0 = 1'b1; rd_ch0 = ch; rd_sel0 = sel;
        q0_exp.push_back(exp); q0_tag.push_back(tag);
        @(negedge clk);
        rd_en0 = 1'b0;
    endtask

    task automatic rd1(input logic [1:0] ch, input logic [2:0] sel, input logic [3:0] exp,
                       input string tag);
        rd_en1 = 1'b1; rd_ch1 = ch; rd_sel1 = sel;
        q1_exp.push_back(exp); q1_tag.push_back(tag);
        @(negedge clk);
        rd_en1 = 1'b0;
    endtask

    // One-cycle event on a d0 channel at timestamp ts (ts < 0: right now).
    task automatic ev0(input int ch, input logic s, input logic d, input int ts);
        if (ts >= 0) goto_ts(ts);
        st0[ch] = s; rdy0[ch] = s; dn0[ch] = d;
        @(negedge clk);
        st0[ch] = 1'b0; rdy0[ch] = 1'b0; dn0[ch] = 1'b0;
    endtask

    task automatic ev1(input int ch, input logic s, input logic d, input int ts);
        if (ts >= 0) goto_ts(ts);
        st1[ch] = s; rdy1[ch] = s; dn1[ch] = d;
        @(negedge clk);
        st1[ch] = 1'b0; rdy1[ch] = 1'b0; dn1[ch] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fin0 = 1'b0; clr0 = 1'b0; rd_en0 = 1'b0; rd_ch0 = 2'd0; rd_sel0 = 3'd0;
        st0 = 4'h0; rdy0 = 4'h0; dn0 = 4'h0; ct0 = 4'hF;
        fin1 = 1'b0; clr1 = 1'b0; rd_en1 = 1'b0; rd_ch1 = 2'd0; rd_sel1 = 3'd0;
        st1 = 3'h0; rdy1 = 3'h0; dn1 = 3'h0; ct1 = 3'h7;
        @(negedge clk);
        chk({31'd0, rd_valid0}, 32'd0, "reset_rd_valid");
        chk(rd_data0, 32'd0, "reset_rd_data");
        chk({31'd0, err_any0}, 32'd0, "reset_err_any");
        do_reset();
        rd0(2'd0, 3'd4, 32'hFFFF_FFFF, "reset_min_lat");
        rd0(2'd0, 3'd0, 32'd0, "reset_started");

        // Single transaction on ch0: push at ts 10, pop at ts 25.
        do_reset();
        ev0(0, 1'b1, 1'b0, 10);
        rd0(2'd0, 3'd6, 32'd1, "A_occ1");
        goto_ts(25);
        dn0[0] = 1'b1;
        rd0(2'd0, 3'd1, 32'd0, "A_pre_edge_completed");
        dn0[0] = 1'b0;
        rd0(2'd0, 3'd0, 32'd1, "A_started");
        rd0(2'd0, 3'd1, 32'd1, "A_completed");
        rd0(2'd0, 3'd2, 32'd15, "A_last_lat");
        rd0(2'd0, 3'd3, 32'd15, "A_max_lat");
        rd0(2'd0, 3'd4, 32'd15, "A_min_lat");
        rd0(2'd0, 3'd6, 32'd0, "A_status");

        // Overlapping transactions on ch1.
        do_reset();
        ev0(1, 1'b1, 1'b0, 0);
        ev0(1, 1'b1, 1'b0, 2);
        ev0(1, 1'b1, 1'b0, 4);
        ev0(1, 1'b0, 1'b1, 10);
        rd0(2'd1, 3'd2, 32'd10, "B_lat0");
        ev0(1, 1'b0, 1'b1, 13);
        rd0(2'd1, 3'd2, 32'd11, "B_lat1");
        ev0(1, 1'b0, 1'b1, 20);
        rd0(2'd1, 3'd2, 32'd16, "B_lat2");
        rd0(2'd1, 3'd3, 32'd16, "B_max_lat");
        rd0(2'd1, 3'd4, 32'd10, "B_min_lat");
        rd0(2'd1, 3'd6, 32'd0, "B_status");
        rd0(2'd1, 3'd1, 32'd3, "B_completed");
        rd0(2'd2, 3'd7, 32'(tb_ts), "B_ts");

        // Overflow on ch2; full push+pop on ch3.
        do_reset();
        st0[2] = 1'b1; rdy0[2] = 1'b1;
        repeat (5) @(negedge clk);
        st0[2] = 1'b0; rdy0[2] = 1'b0;
        chk({31'd0, err_any0}, 32'd0, "C_err_any_delay");
        @(negedge clk);
        chk({31'd0, err_any0}, 32'd1, "C_err_any");
        rd0(2'd2, 3'd0, 32'd5, "C_started");
        rd0(2'd2, 3'd6, 32'h8000_0004, "C_status_ovf");
        st0[3] = 1'b1; rdy0[3] = 1'b1;
        repeat (4) @(negedge clk);
        dn0[3] = 1'b1;
        @(negedge clk);
        st0[3] = 1'b0; rdy0[3] = 1'b0; dn0[3] = 1'b0;
        rd0(2'd3, 3'd6, 32'h0000_0004, "C_full_pushpop_status");
        rd0(2'd3, 3'd0, 32'd5, "C_full_started");
        rd0(2'd3, 3'd1, 32'd1, "C_full_completed");
        rd0(2'd3, 3'd2, 32'd4, "C_full_lat");

        // Stall, bypass and underflow.
        do_reset();
        ev0(0, 1'b1, 1'b0, -1);
        dn0[0] = 1'b1; ct0[0] = 1'b0;
        repeat (3) @(negedge clk);
        ct0[0] = 1'b1;
        @(negedge clk);
        dn0[0] = 1'b0;
        rd0(2'd0, 3'd5, 32'd3, "D_stall_cyc");
        rd0(2'd0, 3'd1, 32'd1, "D_completed");
        rd0(2'd0, 3'd2, 32'd4, "D_lat");
        ev0(0, 1'b1, 1'b1, -1);
        rd0(2'd0, 3'd2, 32'd0, "D_bypass_lat");
        rd0(2'd0, 3'd4, 32'd0, "D_bypass_min");
        rd0(2'd0, 3'd3, 32'd4, "D_bypass_max");
        rd0(2'd0, 3'd0, 32'd2, "D_started");
        rd0(2'd0, 3'd1, 32'd2, "D_completed2");
        rd0(2'd0, 3'd6, 32'd0, "D_status");
        chk({31'd0, err_any0}, 32'd0, "D_no_err");
        ev0(1, 1'b0, 1'b1, -1);
        chk({31'd0, err_any0}, 32'd0, "D_udf_err_delay");
        @(negedge clk);
        chk({31'd0, err_any0}, 32'd1, "D_udf_err_any");
        rd0(2'd1, 3'd1, 32'd1, "D_udf_completed");
        rd0(2'd1, 3'd4, 32'hFFFF_FFFF, "D_udf_min_unchanged");
        rd0(2'd1, 3'd6, 32'h4000_0000, "D_udf_status");

        // Narrow instance: timestamp wrap, saturation, freeze and clear.
        do_reset();
        ev1(0, 1'b1, 1'b0, 14);
        ev1(0, 1'b0, 1'b1, 19);
        rd1(2'd0, 3'd2, 4'd5, "E_wrap_lat");
        rd1(2'd0, 3'd4, 4'd5, "E_wrap_min");
        st1[1] = 1'b1; rdy1[1] = 1'b1;
        repeat (17) @(negedge clk);
        st1[1] = 1'b0; rdy1[1] = 1'b0;
        rd1(2'd1, 3'd0, 4'd15, "E_sat_started");
        chk({31'd0, err_any1}, 32'd1, "E_err_any");
        rd1(2'd3, 3'd0, 4'd0, "E_ch_out_of_range");
        fin1 = 1'b1;
        @(negedge clk);
        fin1 = 1'b0;
        st1[0] = 1'b1; rdy1[0] = 1'b1;
        repeat (2) @(negedge clk);
        st1[0] = 1'b0; rdy1[0] = 1'b0;
        rd1(2'd0, 3'd0, 4'd1, "F_frozen_started");
        rd1(2'd0, 3'd6, 4'h2, "F_frozen_status");
        rd1(2'd1, 3'd6, 4'hA, "F_frozen_status_ch1");
        rd1(2'd0, 3'd7, 4'(tb_ts), "F_ts_running");
        fin1 = 1'b1; clr1 = 1'b1; st1[0] = 1'b1; rdy1[0] = 1'b1;
        @(negedge clk);
        fin1 = 1'b0; clr1 = 1'b0; st1[0] = 1'b0; rdy1[0] = 1'b0;
        rd1(2'd0, 3'd0, 4'd0, "F_clear_started");
        rd1(2'd0, 3'd4, 4'hF, "F_clear_min_lat");
        rd1(2'd0, 3'd3, 4'd0, "F_clear_max_lat");
        rd1(2'd0, 3'd6, 4'h0, "F_clear_status");
        rd1(2'd1, 3'd0, 4'd0, "F_clear_started_ch1");
        chk({31'd0, err_any1}, 32'd0, "F_clear_err_any");
        ev1(0, 1'b1, 1'b0, -1);
        rd1(2'd0, 3'd0, 4'd1, "F_unfrozen_started");

        // Reset in the middle of a transaction and a pending readout.
        do_reset();
        ev0(0, 1'b1, 1'b0, -1);
        ev0(1, 1'b0, 1'b1, -1);
        @(negedge clk);
        rd_en0 = 1'b1; rd_ch0 = 2'd0; rd_sel0 = 3'd0;
        @(posedge clk);
        #2;
        rd_en0 = 1'b0;
        chk({31'd0, rd_valid0}, 32'd1, "G_pre_reset_valid");
        chk(rd_data0, 32'd1, "G_pre_reset_data");
        chk({31'd0, err_any0}, 32'd1, "G_pre_reset_err");
        rst_n = 1'b0;
        #1;
        chk({31'd0, rd_valid0}, 32'd0, "G_async_rd_valid");
        chk(rd_data0, 32'd0, "G_async_rd_data");
        chk({31'd0, err_any0}, 32'd0, "G_async_err_any");
        @(negedge clk);
        rst_n = 1'b1;
        ev0(0, 1'b1, 1'b0, -1);
        rd0(2'd0, 3'd0, 32'd1, "G_first_event");
        rd0(2'd0, 3'd1, 32'd0, "G_completed");
        rd0(2'd0, 3'd4, 32'hFFFF_FFFF, "G_min_lat");
        rd0(2'd0, 3'd6, 32'd1, "G_status");

        repeat (3) @(negedge clk);
        chk(32'(q0_exp.size()), 32'd0, "d0_missing_valid");
        chk(32'(q1_exp.size()), 32'd0, "d1_missing_valid");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
